// File: rtl/dl_mem_writer.sv
// dl_mem_writer: turns the download stage's write stream into request/ack
// byte writes on the shared memory port.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   dl_downloading    download session active
//   dl_wr             write strobe (may be held high across writes)
//   dl_addr, dl_data  write byte address / data
//   mem_req           memory write request, held until mem_ack
//   mem_addr, mem_din memory write address / data
//   mem_ack           one-cycle acknowledge from the memory controller
//   cpu_hold          keep the CPU off the memory bus
//   cpu_reset         post-download CPU reset pulse
//   busy              FIFO non-empty or a request outstanding
//   overflow          sticky: a write was dropped this session
//   byte_count        bytes accepted in the current session
module dl_mem_writer #(
  parameter int unsigned FIFO_AW      = 3,
  parameter bit          AUTO_RESET   = 1'b1,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_downloading,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        cpu_reset,
  output logic        busy,
  output logic        overflow,
  output logic [24:0] byte_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e             state_q, state_d;
  logic [24:0]        fifo_addr_q [DEPTH];
  logic [7:0]         fifo_data_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               prev_wr_q, prev_dl_q;
  logic [24:0]        last_addr_q;
  logic               session_q, session_d;
  logic               mem_req_q, mem_req_d;
  logic [24:0]        mem_addr_q, mem_addr_d;
  logic [7:0]         mem_din_q, mem_din_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [24:0]        byte_count_q, byte_count_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic [CW-1:0]      rst_cnt_q, rst_cnt_d;
  logic               cpu_hold_q;

  logic capture, fifo_empty, fifo_full, push, drop, pop, dl_rise, complete;

  // A held strobe is seen once; a held strobe with a moving address is a new write.
  assign capture    = dl_wr & (~prev_wr_q | (dl_addr != last_addr_q));
  assign fifo_empty = (count_q == '0);
  // Fullness uses the pre-pop count, so a write into a full FIFO is dropped
  // even when the head is being popped in the same cycle.
  assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign push       = capture & ~fifo_full;
  assign drop       = capture & fifo_full;
  assign dl_rise    = dl_downloading & ~prev_dl_q;
  assign complete   = ~dl_downloading & fifo_empty & (state_q == IDLE) & session_q;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = fifo_addr_q[rd_ptr_q];
          mem_din_d  = fifo_data_q[rd_ptr_q];
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            mem_addr_d = fifo_addr_q[rd_ptr_q];
            mem_din_d  = fifo_data_q[rd_ptr_q];
          end else begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    busy_d = (count_d != '0) | (state_d == REQ);
  end

  always_comb begin
    session_d = session_q;
    if (dl_rise)       session_d = 1'b1;
    else if (complete) session_d = 1'b0;

    ovf_d = ovf_q;
    if (dl_rise) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    byte_count_d = byte_count_q;
    if (dl_rise)
      byte_count_d = '0;
    else if (push && session_q && byte_count_q != '1)
      byte_count_d = byte_count_q + 1'b1;

    cpu_reset_d = cpu_reset_q;
    rst_cnt_d   = rst_cnt_q;
    if (complete && AUTO_RESET) begin
      cpu_reset_d = 1'b1;
      rst_cnt_d   = CW'(RESET_CYCLES - 1);
    end else if (dl_rise) begin
      cpu_reset_d = 1'b0;
    end else if (cpu_reset_q) begin
      if (rst_cnt_q == '0) cpu_reset_d = 1'b0;
      else                 rst_cnt_d   = rst_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      prev_wr_q    <= 1'b0;
      prev_dl_q    <= 1'b0;
      last_addr_q  <= '0;
      session_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      byte_count_q <= '0;
      cpu_reset_q  <= 1'b0;
      rst_cnt_q    <= '0;
      cpu_hold_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      prev_wr_q    <= dl_wr;
      prev_dl_q    <= dl_downloading;
      session_q    <= session_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      byte_count_q <= byte_count_d;
      cpu_reset_q  <= cpu_reset_d;
      rst_cnt_q    <= rst_cnt_d;
      cpu_hold_q   <= dl_downloading | session_d | busy_d | cpu_reset_d;
      if (capture) last_addr_q <= dl_addr;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= dl_addr;
        fifo_data_q[wr_ptr_q] <= dl_data;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign cpu_hold   = cpu_hold_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign byte_count = byte_count_q;

endmodule
